muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: CYCLES, default 32, number of iteration cycles spent in CALC.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request strobe; sampled on the rising edge.
REQ-005 funct  input  6  operation select: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x11 mthi, 0x13 mtlo.
REQ-006 x  input  32  rs operand (multiplicand/dividend; mthi/mtlo write data).
REQ-007 y  input  32  rt operand (multiplier/divisor).
REQ-008 busy  output  1  high while in CALC; the pipeline stalls mfhi/mflo and new muldiv ops while high.
REQ-009 done  output  1  one-cycle pulse; hi/lo hold the new result during this cycle.
REQ-010 hi  output  32  HI register; feeds the ALU x input for mfhi.
REQ-011 lo  output  32  LO register; feeds the ALU x input for mflo.

Function
REQ-012 FSM states are IDLE, CALC and DONE.
REQ-013 IDLE/DONE -> CALC: start=1 with funct in {0x18..0x1B}; operands, sign flags and op type latched; iteration counter cleared.
REQ-014 Start with funct 0x11: hi<=x on that edge; no state change; no done pulse.
REQ-015 Start with funct 0x13: lo<=x on that edge; no state change; no done pulse.
REQ-016 Start with any other funct: ignored.
REQ-017 CALC: one iteration per cycle (shift-add multiply; restoring divide on magnitudes).
REQ-018 CALC -> DONE: on the edge where counter==CYCLES-1; hi/lo written on that same edge.
REQ-019 DONE -> IDLE: next edge, unless a new start is accepted (back-to-back ops allowed).
REQ-020 Latency: start sampled at edge E0; done=1 and results valid after edge E32; busy=1 for exactly 32 cycles.
REQ-021 Start while in CALC: ignored (all funct values, including mthi/mtlo); the in-flight op is unaffected.
REQ-022 mult/multu: {hi,lo} = full 64-bit product; signed (two's complement) for mult, unsigned for multu.
REQ-023 div/divu: lo = quotient, hi = remainder.
REQ-024 Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-025 Signed sign correction is applied to the magnitude result on the CALC->DONE edge.
REQ-026 Divide by zero (div and divu): lo=0xFFFFFFFF, hi=x; full 32-cycle latency.
REQ-027 div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0; no exception.
REQ-028 hi/lo hold their values in all cases other than REQ-014, REQ-015 and REQ-018.

Reset
REQ-029 rst=1 at an edge: state<=IDLE, hi<=0, lo<=0, busy=0, done=0, counter<=0.
REQ-030 Reset mid-CALC aborts the op with no partial write to hi/lo.
REQ-031 rst has priority over start in the same cycle.
REQ-032 First start is accepted on the first edge with rst=0.

Structure
REQ-033 A shared package holds the funct constants (MULT, MULTU, DIV, DIVU, MTHI, MTLO) and the FSM state encoding.
REQ-034 One combinational sub-module, cond_neg32 (32-bit conditional two's-complement negate), is used for operand absolute values and result sign fix.
REQ-035 Datapath: 64-bit accumulator/remainder, 32-bit multiplier/quotient shift register, 5-bit counter.

Verification
REQ-036 mult x=0xFFFFFFFD (-3), y=7 -> after 32 busy cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-037 multu x=0xFFFFFFFF, y=2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-038 div x=0xFFFFFFF9 (-7), y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu x=7, y=0 -> lo=0xFFFFFFFF, hi=7.
REQ-039 divu x=100, y=7 with a start (mthi x=5) issued at CALC cycle 5 -> second start ignored; final hi=2, lo=14.
REQ-040 rst pulsed at CALC cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; a following mult 3*4 gives lo=12, hi=0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// funct codes, FSM encoding and operation decode helpers.
package muldiv_unit_pkg;

    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MTLO  = 6'h13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == MULT) || (f == MULTU) || (f == DIV) || (f == DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == MULT) || (f == DIV);
    endfunction

    function automatic logic is_div_op(input logic [5:0] f);
        return (f == DIV) || (f == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_cond_neg32.sv
// 32-bit conditional two's-complement negate, used both for operand
// magnitudes and for restoring the sign of the result.
module cond_neg32 (
    input  logic [31:0] a,
    input  logic        neg,
    output logic [31:0] y
);

    assign y = neg ? (~a + 32'd1) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one iteration per clock, sign fixed at the end.
//
//   state | meaning
//   IDLE  | waiting for a start; mthi/mtlo writes accepted
//   CALC  | iterating; busy high, new starts ignored
//   DONE  | one-cycle result pulse; a new start may be accepted
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] LAST = 5'(CYCLES - 1);

    state_t      state;
    logic [63:0] acc;
    logic [31:0] mq;
    logic [31:0] opd;
    logic [4:0]  cnt;
    logic        op_div;
    logic        neg_q;
    logic        neg_r;
    logic        dz;

    logic        sx_in;
    logic        sy_in;
    logic [31:0] x_abs;
    logic [31:0] y_abs;

    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [33:0] rem_diff;
    logic        q_bit;
    logic [63:0] acc_nxt;
    logic [31:0] mq_nxt;
    logic [31:0] res_lo_m;
    logic [31:0] res_hi_m;
    logic [31:0] lo_fix;
    logic [31:0] hi_neg;
    logic [31:0] hi_fix;

    assign sx_in = is_signed_op(funct) & x[31];
    assign sy_in = is_signed_op(funct) & y[31];

    cond_neg32 u_abs_x (.a(x), .neg(sx_in), .y(x_abs));
    cond_neg32 u_abs_y (.a(y), .neg(sy_in), .y(y_abs));

    // Multiply: acc[63:32] accumulates, product bits shift into acc[31:0].
    // Divide: acc[63:32] is the partial remainder, mq shifts dividend out / quotient in.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (mq[0] ? {1'b0, opd} : 33'd0);
        rem_sh   = {acc[63:32], mq[31]};
        rem_diff = {1'b0, rem_sh} - {2'b00, opd};
        q_bit    = ~rem_diff[33];
        if (op_div) begin
            acc_nxt = {(q_bit ? rem_diff[31:0] : rem_sh[31:0]), 32'd0};
            mq_nxt  = {mq[30:0], q_bit};
        end else begin
            acc_nxt = {mul_sum, acc[31:1]};
            mq_nxt  = {1'b0, mq[31:1]};
        end
        res_lo_m = op_div ? mq_nxt : acc_nxt[31:0];
        res_hi_m = acc_nxt[63:32];
    end

    cond_neg32 u_fix_lo (.a(res_lo_m), .neg(neg_q), .y(lo_fix));
    cond_neg32 u_fix_hi (.a(res_hi_m), .neg(neg_r), .y(hi_neg));

    // A 64-bit product negate borrows out of the high word unless the low word is zero.
    assign hi_fix = (!op_div && neg_r && (res_lo_m != 32'd0)) ? (hi_neg - 32'd1) : hi_neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            hi     <= 32'd0;
            lo     <= 32'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            mq     <= 32'd0;
            opd    <= 32'd0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            case (state)
                CALC: begin
                    acc <= acc_nxt;
                    mq  <= mq_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= hi_fix;
                        lo    <= dz ? 32'hFFFF_FFFF : lo_fix;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    if (start) begin
                        if (is_muldiv(funct)) begin
                            state  <= CALC;
                            busy   <= 1'b1;
                            cnt    <= 5'd0;
                            acc    <= 64'd0;
                            mq     <= x_abs;
                            opd    <= y_abs;
                            op_div <= is_div_op(funct);
                            neg_q  <= sx_in ^ sy_in;
                            neg_r  <= is_div_op(funct) ? sx_in : (sx_in ^ sy_in);
                            dz     <= is_div_op(funct) && (y == 32'd0);
                        end else if (funct == MTHI) begin
                            hi <= x;
                        end else if (funct == MTLO) begin
                            lo <= x;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO,
// a monitor pops and compares whenever done is seen.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h00;
    logic [31:0] x = 32'd0;
    logic [31:0] y = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] l;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    muldiv_unit #(.CYCLES(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct(funct),
        .x(x), .y(y), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result (hi=%h lo=%h)", hi, lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_hi", hi, e.h);
                check("result_lo", lo, e.l);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the sampling edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        funct = f;
        x     = a;
        y     = b;
        @(negedge clk);
        start = 1'b0;
        funct = 6'h00;
    endtask

    task automatic wait_done(output int cnt);
        logic seen;
        seen = 1'b0;
        cnt  = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) cnt++;
            @(negedge clk);
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        int cnt;
        sb.push_back('{h: v.h, l: v.l});
        issue(v.f, v.a, v.b);
        wait_done(cnt);
        check("busy_cycles", 32'(cnt), 32'd32);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[4] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[6] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[8] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{MULTU, 32'hDEADBEEF, 32'h00000010, 32'h0000000D, 32'hEADBEEF0};

        repeat (3) @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // First start lands on the first edge with rst low.
        rst = 1'b0;
        issue(MTHI, 32'h12345678, 32'd0);
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(MTLO, 32'h9ABCDEF0, 32'd0);
        check("mtlo_lo", lo, 32'h9ABCDEF0);
        check("mtlo_hi_held", hi, 32'h12345678);

        issue(6'h10, 32'h55555555, 32'h3);
        check("bad_funct_busy", 32'(busy), 32'd0);
        check("bad_funct_hi", hi, 32'h12345678);
        check("bad_funct_lo", lo, 32'h9ABCDEF0);

        // Back-to-back: each op starts on the cycle the previous done is visible.
        foreach (vecs[i]) run_op(vecs[i]);
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        check("hold_hi", hi, 32'h0000000D);
        check("hold_lo", lo, 32'hEADBEEF0);

        // A start during CALC (mthi here) must be ignored.
        sb.push_back('{h: 32'd2, l: 32'd14});
        issue(DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        issue(MTHI, 32'd5, 32'd0);
        check("mid_calc_hi", hi, 32'h0000000D);
        wait_done(cnt);
        @(negedge clk);

        // Reset mid-CALC: no result, no done, registers cleared.
        issue(MULT, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);

        run_op('{MULT, 32'd3, 32'd4, 32'd0, 32'd12});
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
